lab2_serial_adder: RTL and testbench
====================================

# lab2_serial_adder

Bit-serial N-bit adder with a start/done handshake: the addition counterpart to the combinational 4-bit borrow-lookahead subtractor. It latches two operands and a carry-in, then adds one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It returns a registered sum, carry-out and signed-overflow flag. It sits beside the subtractor as the area-minimal arithmetic unit and shares its operand/flag conventions (X, Y, carry/borrow-in, N=4 default).

## Interface
- N, 4, operand and sum width in bits (N ≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- X  input  N  augend, sampled with start
- Y  input  N  addend, sampled with start
- Cin  input  1  carry-in, sampled with start
- busy  output  1  high while bits are being added
- done  output  1  one-cycle pulse when result is valid
- Sum  output  N  result, X+Y+Cin mod 2^N
- Cout  output  1  unsigned carry-out
- Ovf  output  1  signed (two's-complement) overflow

## Operation
- FSM states:
  - IDLE: start=1 → ADD. Latch X, Y, Cin into shift registers a, b and carry flop c. Clear bit counter.
  - ADD: each cycle, s = a[0]^b[0]^c and c' = maj(a[0],b[0],c). Shift s into the MSB of internal sum register sr. Shift a and b right. Increment counter. After the N-th bit → DONE.
  - DONE: lasts exactly one cycle → IDLE.
- Sum, Cout and Ovf are copied from sr, the final carry and (carry into MSB ^ carry out of MSB) on the ADD→DONE transition only. They hold that value until the next ADD→DONE transition. They never show partial results.
- busy = (state==ADD); done = (state==DONE); both decoded from registered state.
- start is ignored in ADD and DONE (no queuing). X/Y/Cin changes after capture have no effect.
- Counter width is clog2(N)+1. There is no wrap-around; the counter is cleared on entering ADD.

## Timing
- Reset (asynchronous, any state, including mid-ADD): state=IDLE, busy=0, done=0, Sum=0, Cout=0, Ovf=0. Internal registers are cleared and any in-flight operation is discarded.
- After reset deassertion, the first start is accepted at the first rising edge where rst_n=1 and start=1.
- start sampled at edge E0 → busy=1 from E0 through edge E0+N. Bits are processed at edges E0+1 … E0+N.
- done=1 and new Sum/Cout/Ovf are visible after edge E0+N, held for one cycle. busy=0 in that cycle.
- Latency from start edge to done: N cycles. Minimum start-to-start spacing: N+2 cycles.
- start held high continuously yields one operation per N+2 cycles.

## Structure
- Shared package lab2_pkg: state encoding localparams IDLE=2'b00, ADD=2'b01, DONE=2'b10, and the default width constant 4. The subtractor bench and this block both import it.
- One sub-module: lab2_full_adder (a, b, ci → s, co), purely combinational. Instantiated once, fed by a[0], b[0], c.
- The top holds the FSM, counter, shift registers and output registers.

## Test plan
- X=1101, Y=0101, Cin=0, start → done 4 cycles after start. Sum=0010, Cout=1, Ovf=0.
- X=0101, Y=0101, Cin=0 → Sum=1010, Cout=0, Ovf=1. X=1100, Y=1000, Cin=1 → Sum=0101, Cout=1, Ovf=1.
- X=0000, Y=1111, Cin=1 → Sum=0000, Cout=1, Ovf=0. X=0000, Y=1111, Cin=0 → Sum=1111, Cout=0, Ovf=0.
- Pulse start again with X=1111, Y=1111 two cycles into ADD → ignored. The result matches the first operands, and only one done pulse occurs.
- Drop rst_n during the 3rd ADD cycle → all outputs 0 immediately and state IDLE. A fresh start afterwards gives the correct result with no residue.
- Hold start=1 for 20 cycles with fixed operands → done pulses every 6 cycles. busy is never high in a done cycle, and Sum is stable between pulses.

Source files
------------

// File: rtl/lab2_pkg.sv
// lab2_pkg
// Shared definitions for the lab2 arithmetic blocks (serial adder and
// borrow-lookahead subtractor): FSM state encoding and default width.
// No ports; imported with "import lab2_pkg::*;".
package lab2_pkg;

  // Default operand width shared by the lab2 arithmetic units.
  localparam int unsigned LAB2_N = 4;

  // Sequencer state encoding. Kept as plain 2-bit constants so the
  // encoding stays identical to the older benches that compare raw values.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] ADD  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  typedef logic [1:0] lab2_state_t;

  // Result flags that travel together with the sum.
  typedef struct packed {
    logic cout;
    logic ovf;
  } lab2_flags_t;

endpackage

// File: rtl/lab2_full_adder.sv
// lab2_full_adder
// One-bit combinational full adder; the only arithmetic cell of the
// bit-serial adder.
// Ports:
//   a, b  : operand bits
//   ci    : carry in
//   s     : sum bit       (a ^ b ^ ci)
//   co    : carry out     (majority of a, b, ci)
module lab2_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/lab2_serial_adder.sv
// lab2_serial_adder
// Bit-serial N-bit adder with start/done handshake. Operands and carry-in
// are latched on start, then one bit per clock is added LSB first through a
// single full-adder cell and a carry flop. Sum/Cout/Ovf are registered and
// only change when the last bit has been added.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request, sampled only in IDLE
//   X, Y   : N-bit operands, sampled with start
//   Cin    : carry-in, sampled with start
//   busy   : high while bits are being added (state ADD)
//   done   : one-cycle pulse when Sum/Cout/Ovf are fresh (state DONE)
//   Sum    : X+Y+Cin mod 2^N
//   Cout   : unsigned carry-out
//   Ovf    : two's-complement overflow
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands latched on the accepting edge
// ADD   | one bit per cycle through the full adder, N cycles total
// DONE  | result registers just updated; one cycle, then back to IDLE
module lab2_serial_adder
  import lab2_pkg::*;
#(
  parameter int unsigned N = LAB2_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic         Cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Ovf
);

  localparam int unsigned CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  lab2_state_t   state_q, state_d;
  logic [N-1:0]  a_q,     a_d;
  logic [N-1:0]  b_q,     b_d;
  logic          c_q,     c_d;
  logic [N-1:0]  sr_q,    sr_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [N-1:0]  sum_q,   sum_d;
  lab2_flags_t   flags_q, flags_d;

  logic fa_s;
  logic fa_co;

  lab2_full_adder u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (c_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    flags_d = flags_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADD;
          a_d     = X;
          b_d     = Y;
          c_d     = Cin;
          sr_d    = '0;
          cnt_d   = '0;
        end
      end

      ADD: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_co;
        sr_d  = {fa_s, sr_q[N-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d      = DONE;
          // Take the final bit straight from the adder so the published
          // sum is complete on the same edge the FSM leaves ADD.
          sum_d        = {fa_s, sr_q[N-1:1]};
          flags_d.cout = fa_co;
          // c_q is the carry into the MSB while the MSB is being added.
          flags_d.ovf  = c_q ^ fa_co;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sr_q    <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    busy = (state_q == ADD);
    done = (state_q == DONE);
    Sum  = sum_q;
    Cout = flags_q.cout;
    Ovf  = flags_q.ovf;
  end

endmodule

// File: tb/tb_lab2_serial_adder.sv
// tb_lab2_serial_adder
// Self-checking bench for lab2_serial_adder (N=4): table-driven vectors,
// random vectors against a reference model, and hand-written sequences for
// ignored start, mid-operation reset and back-to-back operation.
module tb_lab2_serial_adder;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [N-1:0] Sum;
  logic         Cout;
  logic         Ovf;

  lab2_serial_adder #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .X     (X),
    .Y     (Y),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout),
    .Ovf   (Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  int   done_cycles[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    logic [N:0] t;
    exp_t r;
    t      = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
    r.sum  = t[N-1:0];
    r.cout = t[N];
    r.ovf  = (x[N-1] == y[N-1]) && (t[N-1] != x[N-1]);
    return r;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n && done) begin
      done_cycles.push_back(cyc);
      check("busy_low_in_done", 32'(busy), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no pending result (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("sum",  32'(Sum),  32'(e.sum));
        check("cout", 32'(Cout), 32'(e.cout));
        check("ovf",  32'(Ovf),  32'(e.ovf));
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while ((busy || done) && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%0b done=%0b, expected idle", busy, done);
    end
  endtask

  // Drive one operation, check busy during ADD and the start-to-done latency.
  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic cin, input exp_t e);
    int k;
    wait_idle();
    X = x; Y = y; Cin = cin; start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    k = 0;
    while (k < 10) begin
      @(posedge clk);
      #1;
      k++;
      if (done) break;
      check("busy_during_add", 32'(busy), 32'd1);
    end
    check("latency", 32'(k), 32'(N));
  endtask

  vec_t vecs[8];

  initial begin
    exp_t e;
    exp_t ec;
    int   n0;
    logic [N-1:0] rx, ry;
    logic rc;
    bit   seen;

    vecs[0] = '{4'b1101, 4'b0101, 1'b0, 4'b0010, 1'b1, 1'b0};
    vecs[1] = '{4'b0101, 4'b0101, 1'b0, 4'b1010, 1'b0, 1'b1};
    vecs[2] = '{4'b1100, 4'b1000, 1'b1, 4'b0101, 1'b1, 1'b1};
    vecs[3] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b0};
    vecs[4] = '{4'b0000, 4'b1111, 1'b0, 4'b1111, 1'b0, 1'b0};
    vecs[5] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1};
    vecs[6] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1};
    vecs[7] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; X = '0; Y = '0; Cin = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(Sum),  32'd0);
    check("rst_cout", 32'(Cout), 32'd0);
    check("rst_ovf",  32'(Ovf),  32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_sum",  32'(Sum),  32'd0);

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      e.sum = vecs[i].sum; e.cout = vecs[i].cout; e.ovf = vecs[i].ovf;
      run_op(vecs[i].x, vecs[i].y, vecs[i].cin, e);
    end

    // Random vectors against the reference model.
    for (int i = 0; i < 10; i++) begin
      rx = 4'($urandom_range(0, 15));
      ry = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      run_op(rx, ry, rc, model(rx, ry, rc));
    end

    // start pulsed two cycles into ADD with new operands must be ignored.
    wait_idle();
    n0 = done_cycles.size();
    X = 4'b1101; Y = 4'b0101; Cin = 1'b0; start = 1'b1;
    sb.push_back(model(4'b1101, 4'b0101, 1'b0));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    X = 4'b1111; Y = 4'b1111; Cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("ignored_start_done_count", 32'(done_cycles.size() - n0), 32'd1);
    check("ignored_start_sum", 32'(Sum), 32'b0010);

    // Reset during the third ADD cycle discards the operation.
    wait_idle();
    X = 4'b0110; Y = 4'b0111; Cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum",  32'(Sum),  32'd0);
    check("midrst_cout", 32'(Cout), 32'd0);
    check("midrst_ovf",  32'(Ovf),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("after_midrst_sum", 32'(Sum), 32'd0);
    run_op(4'b0011, 4'b0110, 1'b0, model(4'b0011, 4'b0110, 1'b0));

    // start held high for 20 cycles: one operation every N+2 cycles.
    wait_idle();
    done_cycles.delete();
    ec = model(4'b1010, 4'b0111, 1'b1);
    for (int i = 0; i < 4; i++) sb.push_back(ec);
    X = 4'b1010; Y = 4'b0111; Cin = 1'b1; start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 19) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        check("cont_busy_in_done", 32'(busy), 32'd0);
      end else if (seen) begin
        check("cont_sum_stable", 32'(Sum), 32'(ec.sum));
      end
    end
    check("cont_done_count", 32'(done_cycles.size()), 32'd4);
    for (int i = 1; i < done_cycles.size(); i++)
      check("cont_done_spacing", 32'(done_cycles[i] - done_cycles[i-1]), 32'(N + 2));

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
